demux8_scheduler: RTL
=====================

// Module: demux8_scheduler
// PURPOSE
//  Round-robin dispatcher in front of DMux8Way16: accepts a 16-bit word stream (valid/ready) into a
//  one-word holding register and steers each word to one of 8 destinations.
//  Drives the demux select sel[2:0] plus per-destination valid strobes, skips busy or masked outputs,
//  and drops a word stuck longer than TIMEOUT cycles. Sits between a producer (e.g. a CPU port) and 8 sinks.
// PARAMETERS
//  TIMEOUT  15  stall cycles in STALL before the held word is dropped (1..255)
//  CW       8   width of the stall counter (must hold TIMEOUT)
// PORTS
//  clock      in   1   system clock, all state on rising edge
//  reset_n    in   1   asynchronous, active-low reset
//  in_data    in   16  word from producer
//  in_valid   in   1   producer offers in_data
//  in_ready   out  1   scheduler accepts; transfer when in_valid & in_ready
//  out_ready  in   8   destination i can take a word this cycle
//  mask       in   8   destination i eligible (0 = never granted)
//  flush      in   1   synchronous discard of held word
//  out_data   out  16  held word, to DMux8Way16 'in'
//  sel        out  3   grant index, to DMux8Way16 'sel'
//  out_valid  out  8   one-hot: word delivered to destination i this cycle
//  drop       out  1   1-cycle pulse: held word discarded by timeout
//  stat_sel   in   3   counter select (STATS feature)
//  stat_count out  16  delivery count of destination stat_sel
// BEHAVIOUR
//  Reset (reset_n=0, async): state=EMPTY, ptr=0, stall_cnt=0, hold_data=0; outputs in_ready=1,
//   out_valid=0, sel=0, out_data=0, drop=0, stat_count=0, all counters 0.
//  Grant: first i in order ptr, ptr+1, ... ptr+7 (mod 8) with out_ready[i]&mask[i]; combinational.
//  States: EMPTY (no word held), FULL (word held, first cycle), STALL (word held, no grant seen).
//  Dispatch: in FULL/STALL with a grant: out_valid[g]=1, sel=g, out_data=hold_data; ptr<=g+1 (mod 8).
//   Outputs are combinational from registered state; sel holds last grant when no dispatch.
//  in_ready = (state==EMPTY) | dispatch; accept+dispatch same cycle => next state FULL, new word held.
//  Latency: word accepted at edge N is dispatchable in cycle N+1; sustained throughput 1 word/cycle.
//  Transitions: EMPTY-accept->FULL; FULL/STALL-dispatch->EMPTY (or FULL if accepting);
//   FULL-no grant->STALL, stall_cnt<=1; STALL-no grant->stall_cnt+1;
//   STALL with stall_cnt==TIMEOUT and no grant -> EMPTY, drop=1 that cycle, ptr unchanged.
//  Grant in the timeout cycle wins: word dispatched, no drop.
//  flush=1: state->EMPTY, stall_cnt=0, no out_valid, no drop, in_ready=0 that cycle; ptr unchanged.
//  mask=0 or out_ready&mask=0 forever: every word drops after TIMEOUT+1 held cycles.
//  stall_cnt cleared on every entry to FULL; saturates at TIMEOUT (no wrap).
//  reset_n deasserting mid-transfer: held word lost, no spurious out_valid on release.
// CONFIGURATION
//  DEMUX_SCHED_STATS_EN defined: eight 16-bit wrapping counters, cnt[i]++ on each out_valid[i];
//   stat_count = cnt[stat_sel] (combinational); counters cleared by reset only, not by flush.
//  Undefined: no counters, stat_count tied 16'h0000, stat_sel ignored; ports kept.
// STRUCTURE
//  Shared header demux_sched_defs.vh (include-guarded): state encodings S_EMPTY=2'd0, S_FULL=2'd1,
//   S_STALL=2'd2, DATA_W=16, N_DEST=8.
//  One sub-module: rr_pick8 (combinational rotating priority encoder: req[7:0], ptr[2:0] -> gnt_idx, gnt_any).
//  Top instantiates rr_pick8 and may instantiate DMux8Way16 only in the testbench wrapper.
// TESTING
//  Round-robin: out_ready=8'hFF, mask=8'hFF, stream 16 words 0x0000..0x000F back to back ->
//   sel cycles 0..7,0..7, word k at dest k%8, one word/cycle, in_ready held 1.
//  Skip: mask=8'hFF, out_ready=8'b1010_0101, 4 words -> dests 0,2,5,7 in order.
//  Timeout: TIMEOUT=15, out_ready=0, send 0xBEEF -> in_ready=0 for 16 cycles, then drop=1 for 1 cycle,
//   no out_valid, state EMPTY, in_ready=1.
//  Late grant: as above but out_ready[3]=1 exactly in timeout cycle -> out_valid=8'h08,
//   out_data=0xBEEF, drop=0.
//  Flush/reset: hold 0x1234 stalled, pulse flush -> no delivery, no drop; then assert reset_n=0 mid-STALL
//   -> all outputs at reset values immediately (async).
//  Stats (STATS_EN): 10 words round robin -> stat_sel=0 reads 2, stat_sel=2 reads 1;
//   without macro reads 0.

Source files
------------

// File: rtl/demux8_scheduler_pkg.sv
// Shared definitions for the demux8_scheduler block.
//   DATA_W / N_DEST : word width and number of destinations
//   state_t         : scheduler FSM encoding (EMPTY=0, FULL=1, STALL=2)
//   onehot8()       : grant index -> one-hot destination strobe
package demux8_scheduler_pkg;

  localparam int DATA_W = 16;
  localparam int N_DEST = 8;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_FULL  = 2'd1,
    S_STALL = 2'd2
  } state_t;

  function automatic logic [N_DEST-1:0] onehot8(input logic [2:0] idx);
    onehot8 = 8'b0000_0001 << idx;
  endfunction

endpackage

// File: rtl/rr_pick8.sv
// Rotating priority encoder for eight requesters.
// Searches req[ptr], req[ptr+1], ... req[ptr+7] (indices mod 8) and returns
// the first set position.
//   req     in  8  request vector (already qualified by ready & mask)
//   ptr     in  3  highest-priority position this cycle
//   gnt_idx out 3  granted index (equals ptr when nothing is requested)
//   gnt_any out 1  at least one request present
module rr_pick8 (
  input  logic [7:0] req,
  input  logic [2:0] ptr,
  output logic [2:0] gnt_idx,
  output logic       gnt_any
);

  always_comb begin
    gnt_idx = ptr;
    gnt_any = 1'b0;
    for (int k = 0; k < 8; k++) begin
      // ptr + k wraps naturally in 3 bits.
      if (!gnt_any && req[ptr + 3'(k)]) begin
        gnt_any = 1'b1;
        gnt_idx = ptr + 3'(k);
      end
    end
  end

endmodule

// File: rtl/demux8_scheduler.sv
// Round-robin dispatcher feeding a DMux8Way16. Accepts 16-bit words over a
// valid/ready input into a one-word holding register and steers each word to
// the next eligible destination (out_ready & mask), rotating priority after
// every delivery. A word that finds no destination for TIMEOUT+1 held cycles
// is dropped with a one-cycle drop pulse.
//
// Handshake: a word moves from producer to scheduler on a rising edge where
// in_valid & in_ready are both 1; in_valid may not depend on in_ready.
// Delivery to destination i happens in a cycle where out_valid[i]=1; the
// destination signalled willingness through out_ready[i] in that same cycle.
//
// Ports:
//   clock, reset_n       clock, asynchronous active-low reset
//   in_data/in_valid/in_ready  producer side
//   out_ready[7:0]       destination can take a word this cycle
//   mask[7:0]            destination eligible for grants
//   flush                synchronous discard of the held word
//   out_data, sel        to DMux8Way16 'in' / 'sel'
//   out_valid[7:0]       one-hot delivery strobe
//   drop                 held word discarded by timeout
//   stat_sel/stat_count  per-destination delivery counter readback
//   dbg_state            current FSM state (state_t encoding)
//
// Optional feature: define DEMUX_SCHED_STATS_EN to build eight 16-bit
// wrapping delivery counters; otherwise stat_count reads 0.
module demux8_scheduler
  import demux8_scheduler_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int CW      = 8
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  out_ready,
  input  logic [7:0]  mask,
  input  logic        flush,
  output logic [15:0] out_data,
  output logic [2:0]  sel,
  output logic [7:0]  out_valid,
  output logic        drop,
  input  logic [2:0]  stat_sel,
  output logic [15:0] stat_count,
  output logic [1:0]  dbg_state
);

  localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);

  state_t              state;
  logic [2:0]          ptr;
  logic [2:0]          last_sel;
  logic [CW-1:0]       stall_cnt;
  logic [DATA_W-1:0]   hold_data;

  logic [2:0]          gnt_idx;
  logic                gnt_any;
  logic                holding;
  logic                dispatch;
  logic                timeout_hit;
  logic                accept;

  rr_pick8 u_pick (
    .req     (out_ready & mask),
    .ptr     (ptr),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  // flush overrides everything: no delivery, no drop, no accept that cycle.
  assign holding     = (state != S_EMPTY);
  assign dispatch    = holding & gnt_any & ~flush;
  // A grant in the timeout cycle wins over the drop.
  assign timeout_hit = (state == S_STALL) & (stall_cnt == TIMEOUT_C) & ~gnt_any & ~flush;
  assign in_ready    = ~flush & (~holding | dispatch);
  assign accept      = in_valid & in_ready;

  assign out_valid = dispatch ? onehot8(gnt_idx) : 8'h00;
  assign sel       = dispatch ? gnt_idx : last_sel;
  assign out_data  = hold_data;
  assign drop      = timeout_hit;
  assign dbg_state = state;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_EMPTY;
      ptr       <= 3'd0;
      last_sel  <= 3'd0;
      stall_cnt <= '0;
      hold_data <= '0;
    end else if (flush) begin
      state     <= S_EMPTY;
      stall_cnt <= '0;
    end else if (dispatch) begin
      ptr      <= gnt_idx + 3'd1;
      last_sel <= gnt_idx;
      if (accept) begin
        state     <= S_FULL;
        hold_data <= in_data;
        stall_cnt <= '0;
      end else begin
        state <= S_EMPTY;
      end
    end else begin
      case (state)
        S_EMPTY: begin
          if (accept) begin
            state     <= S_FULL;
            hold_data <= in_data;
            stall_cnt <= '0;
          end
        end
        S_FULL: begin
          state     <= S_STALL;
          stall_cnt <= CW'(1);
        end
        S_STALL: begin
          if (timeout_hit) begin
            state     <= S_EMPTY;
            stall_cnt <= '0;
          end else if (stall_cnt != TIMEOUT_C) begin
            stall_cnt <= stall_cnt + CW'(1);
          end
        end
        default: state <= S_EMPTY;
      endcase
    end
  end

`ifdef DEMUX_SCHED_STATS_EN
  logic [15:0] cnt [N_DEST];

  // Counters survive flush; only reset clears them.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_DEST; i++) cnt[i] <= 16'h0000;
    end else begin
      for (int i = 0; i < N_DEST; i++) begin
        if (out_valid[i]) cnt[i] <= cnt[i] + 16'h0001;
      end
    end
  end

  assign stat_count = cnt[stat_sel];
`else
  logic unused_stat_sel;
  assign unused_stat_sel = ^stat_sel;
  assign stat_count      = 16'h0000;
`endif

endmodule
